// File: rtl/fir_sm_obuf.sv
// Elastic output buffer between the FIR AXI-Stream master and the Wishbone bridge, with frame tracking.
// Optional feature: define FIR_OBUF_TLAST_CHECK_EN to latch cfg_len and flag tlast/length mismatches.
module fir_sm_obuf #(
    parameter int pDATA_WIDTH = 32,
    parameter int DEPTH       = 8,
    parameter int pLEN_WIDTH  = 10
) (
    input  logic                       axis_clk,
    input  logic                       axis_rst_n,
    input  logic                       s_tvalid,
    input  logic [pDATA_WIDTH-1:0]     s_tdata,
    input  logic                       s_tlast,
    output logic                       s_tready,
    output logic                       m_tvalid,
    output logic [pDATA_WIDTH-1:0]     m_tdata,
    output logic                       m_tlast,
    input  logic                       m_tready,
    input  logic [pLEN_WIDTH-1:0]      cfg_len,
    input  logic                       clr,
    output logic [$clog2(DEPTH):0]     level,
    output logic [pLEN_WIDTH-1:0]      beat_cnt,
    output logic                       frame_done,
    output logic                       tlast_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]           PTR_ONE = 1;
    localparam logic [pLEN_WIDTH-1:0] CNT_ONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [pLEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [pDATA_WIDTH:0]  mem_q [DEPTH];
    logic [pDATA_WIDTH:0]  head;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;

    // Flags come only from registered pointers/state, so s_tready never depends on m_tready.
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign s_tready = !full && ((state_q == ST_IDLE) || (state_q == ST_RUN));
    assign m_tvalid = !empty;

    // A flush in the same cycle discards any handshake.
    assign push = s_tvalid && s_tready && !clr;
    assign pop  = m_tvalid && m_tready && !clr;

    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign m_tdata = empty ? '0 : head[pDATA_WIDTH-1:0];
    assign m_tlast = !empty && head[pDATA_WIDTH];

    assign level      = wr_ptr_q - rd_ptr_q;
    assign beat_cnt   = beat_cnt_q;
    assign frame_done = (state_q == ST_DONE);

    // NOTE: storage is deliberately left without reset; outputs are gated by empty so stale entries never show.
    always_ff @(posedge axis_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {s_tlast, s_tdata};
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (clr) begin
            beat_cnt_d = '0;
        end else if (push && (beat_cnt_q != '1)) begin
            beat_cnt_d = beat_cnt_q + CNT_ONE;
        end
    end

    // A single-beat frame (tlast on the first push) goes straight to DRAIN.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (push) begin
                        state_d = s_tlast ? ST_DRAIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (push && s_tlast) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (wr_ptr_d == rd_ptr_d) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef FIR_OBUF_TLAST_CHECK_EN
    localparam logic [pLEN_WIDTH:0] EXT_ONE = 1;

    logic [pLEN_WIDTH-1:0] len_q, len_d;
    logic [pLEN_WIDTH-1:0] len_eff;
    logic [pLEN_WIDTH:0]   beat_num;
    logic                  len_hit;
    logic                  tlast_err_q, tlast_err_d;

    // One extra bit keeps a saturated count and L=0 from ever matching.
    always_comb begin
        len_eff     = (state_q == ST_IDLE) ? cfg_len : len_q;
        beat_num    = {1'b0, beat_cnt_q} + EXT_ONE;
        len_hit     = (beat_num == {1'b0, len_eff});
        len_d       = len_q;
        tlast_err_d = tlast_err_q;
        if (clr) begin
            len_d       = '0;
            tlast_err_d = 1'b0;
        end else if (push) begin
            if (state_q == ST_IDLE) begin
                len_d = cfg_len;
            end
            if (s_tlast != len_hit) begin
                tlast_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            len_q       <= '0;
            tlast_err_q <= 1'b0;
        end else begin
            len_q       <= len_d;
            tlast_err_q <= tlast_err_d;
        end
    end

    assign tlast_err = tlast_err_q;
`else
    logic unused_cfg_len;

    assign unused_cfg_len = ^cfg_len;
    assign tlast_err      = 1'b0;
`endif

endmodule

// File: tb/tb_fir_sm_obuf.sv
// Scoreboard bench for fir_sm_obuf: accepted samples are queued, a negedge monitor checks every pop.
module tb_fir_sm_obuf;

    logic        axis_clk;
    logic        axis_rst_n;
    logic        s_tvalid;
    logic [31:0] s_tdata;
    logic        s_tlast;
    logic        s_tready;
    logic        m_tvalid;
    logic [31:0] m_tdata;
    logic        m_tlast;
    logic        m_tready;
    logic [9:0]  cfg_len;
    logic        clr;
    logic [3:0]  level;
    logic [9:0]  beat_cnt;
    logic        frame_done;
    logic        tlast_err;

`ifdef FIR_OBUF_TLAST_CHECK_EN
    localparam bit TLAST_CHK = 1'b1;
`else
    localparam bit TLAST_CHK = 1'b0;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [32:0] exp_q[$];

    fir_sm_obuf #(
        .pDATA_WIDTH(32),
        .DEPTH      (8),
        .pLEN_WIDTH (10)
    ) dut (
        .axis_clk  (axis_clk),
        .axis_rst_n(axis_rst_n),
        .s_tvalid  (s_tvalid),
        .s_tdata   (s_tdata),
        .s_tlast   (s_tlast),
        .s_tready  (s_tready),
        .m_tvalid  (m_tvalid),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .cfg_len   (cfg_len),
        .clr       (clr),
        .level     (level),
        .beat_cnt  (beat_cnt),
        .frame_done(frame_done),
        .tlast_err (tlast_err)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        exp_q.delete();
        cycle();
        clr = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input logic l, output bit ok);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        ok       = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (s_tready) begin
                ok = 1'b1;
                cycle();
                break;
            end
            cycle();
        end
        s_tvalid = 1'b0;
    endtask

    // Monitor: the handshake completes at the next posedge, so both sides are sampled on the negedge.
    always @(negedge axis_clk) begin
        if (axis_rst_n && !clr) begin
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_unexpected: got 0x%0h with no sample expected", {m_tlast, m_tdata});
                end else begin
                    check("pop_data", {m_tlast, m_tdata}, exp_q.pop_front());
                end
            end
            if (s_tvalid && s_tready) begin
                exp_q.push_back({s_tlast, s_tdata});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n_ok;
        int n_acc;
        bit seen;

        axis_rst_n = 1'b0;
        s_tvalid   = 1'b0;
        s_tdata    = '0;
        s_tlast    = 1'b0;
        m_tready   = 1'b0;
        cfg_len    = 10'd100;
        clr        = 1'b0;
        repeat (3) @(posedge axis_clk);
        #1;
        axis_rst_n = 1'b1;

        check("rst_s_tready", s_tready, 1);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_level", level, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_tlast_err", tlast_err, 0);

        // Single sample, bridge idle
        do_clr();
        send(32'h1234, 1'b0, ok);
        check("t1_accepted", ok, 1);
        check("t1_m_tvalid", m_tvalid, 1);
        check("t1_m_tdata", m_tdata, 32'h1234);
        check("t1_m_tlast", m_tlast, 0);
        check("t1_level", level, 1);
        check("t1_beat_cnt", beat_cnt, 1);
        m_tready = 1'b1;
        cycle();
        m_tready = 1'b0;
        check("t1_level_after_pop", level, 0);
        check("t1_m_tvalid_after_pop", m_tvalid, 0);

        // Overflow: nine offered, eight fit
        do_clr();
        for (int i = 0; i < 9; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'hA0 + i;
            s_tlast  = 1'b0;
            check("t2_s_tready_fill", s_tready, (i < 8));
            cycle();
        end
        s_tvalid = 1'b0;
        check("t2_level_full", level, 8);
        check("t2_s_tready_full", s_tready, 0);
        check("t2_beat_cnt", beat_cnt, 8);
        m_tready = 1'b1;
        repeat (8) cycle();
        m_tready = 1'b0;
        check("t2_level_drained", level, 0);
        check("t2_sb_empty", exp_q.size(), 0);

        // 64-beat frame, bridge pops every third cycle
        do_clr();
        cfg_len = 10'd64;
        n_ok    = 0;
        seen    = 1'b0;
        fork
            begin
                for (int i = 0; i < 64; i++) begin
                    send(32'h1000 + i, (i == 63), ok);
                    n_ok += int'(ok);
                end
            end
            begin
                for (int t = 0; t < 1000; t++) begin
                    if (frame_done) begin
                        seen = 1'b1;
                        break;
                    end
                    m_tready = ((t % 3) == 2);
                    cycle();
                end
                m_tready = 1'b0;
            end
        join
        check("t3_accepted", n_ok, 64);
        check("t3_frame_done_seen", seen, 1);
        check("t3_sb_empty_at_done", exp_q.size(), 0);
        check("t3_beat_cnt", beat_cnt, 64);
        check("t3_tlast_err", tlast_err, 0);
        check("t3_level", level, 0);
        check("t3_s_tready_done", s_tready, 0);

        // Early tlast on beat 10 of a 64-beat frame
        do_clr();
        check("t4_s_tready_idle", s_tready, 1);
        check("t4_frame_done_clr", frame_done, 0);
        cfg_len  = 10'd64;
        m_tready = 1'b1;
        n_ok     = 0;
        for (int i = 0; i < 10; i++) begin
            send(32'h2000 + i, (i == 9), ok);
            n_ok += int'(ok);
        end
        check("t4_accepted", n_ok, 10);
        check("t4_drain_s_tready", s_tready, 0);
        check("t4_drain_frame_done", frame_done, 0);
        check("t4_beat_cnt", beat_cnt, 10);
        check("t4_tlast_err", tlast_err, TLAST_CHK);
        cycle();
        check("t4_frame_done", frame_done, 1);
        check("t4_level", level, 0);

        // Missing tlast on the final beat of a 3-beat frame
        do_clr();
        check("t4b_tlast_err_clr", tlast_err, 0);
        cfg_len = 10'd3;
        for (int i = 0; i < 3; i++) begin
            send(32'h2100 + i, 1'b0, ok);
        end
        check("t4b_tlast_err", tlast_err, TLAST_CHK);
        check("t4b_still_run", s_tready, 1);

        // Streaming 100 cycles, then flush mid-stream
        do_clr();
        cfg_len  = 10'd0;
        m_tready = 1'b1;
        n_acc    = 0;
        s_tvalid = 1'b1;
        s_tlast  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            s_tdata = 32'h5000 + i;
            if (s_tready) n_acc++;
            cycle();
        end
        check("t5_throughput", n_acc, 100);
        check("t5_level", level, 1);
        check("t5_beat_cnt", beat_cnt, 100);
        s_tdata = 32'hDEAD;
        do_clr();
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        check("t5_clr_level", level, 0);
        check("t5_clr_beat_cnt", beat_cnt, 0);
        check("t5_clr_m_tvalid", m_tvalid, 0);
        check("t5_clr_s_tready", s_tready, 1);
        check("t5_clr_frame_done", frame_done, 0);

        // Asynchronous reset with five samples buffered
        cfg_len = 10'd100;
        for (int i = 0; i < 5; i++) begin
            send(32'h3000 + i, 1'b0, ok);
        end
        check("t6_level", level, 5);
        #2;
        axis_rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("t6_s_tready", s_tready, 1);
        check("t6_m_tvalid", m_tvalid, 0);
        check("t6_m_tdata", m_tdata, 0);
        check("t6_m_tlast", m_tlast, 0);
        check("t6_level_rst", level, 0);
        check("t6_beat_cnt", beat_cnt, 0);
        check("t6_frame_done", frame_done, 0);
        check("t6_tlast_err", tlast_err, 0);
        @(posedge axis_clk);
        #1;
        axis_rst_n = 1'b1;
        cycle();
        check("t6_level_after", level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
